// File: rtl/life_pkg.sv
// Purpose: shared types and helpers for the Game-of-Life map controller.
// Latency: n/a (package: state enum, default grid size, cell index helper).
// Backpressure: n/a.
package life_pkg;

  localparam int LIFE_GRID_W = 10;
  localparam int LIFE_GRID_H = 10;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    WAIT_COMMIT
  } life_state_e;

  // Linear bit position of cell (x,y) in a row-major map of width w.
  function automatic int cell_idx(input int x, input int y, input int w);
    return x + y * w;
  endfunction

endpackage

// File: rtl/life_map_ctrl_if.sv
// Purpose: groups the controller's control inputs and map/status outputs.
// Latency: n/a (wires only).
// Backpressure: none; all inputs are pulses or levels sampled every clk.
// Ports: master drives frame_start/step_req/run_en/btn_*; slave drives
//        map_out, cursor_x/y, busy, gen_count.
interface life_map_ctrl_if
  import life_pkg::*;
#(
  parameter int GRID_W = LIFE_GRID_W,
  parameter int GRID_H = LIFE_GRID_H
);
  logic                     frame_start;
  logic                     step_req;
  logic                     run_en;
  logic                     btn_up;
  logic                     btn_down;
  logic                     btn_left;
  logic                     btn_right;
  logic                     btn_toggle;
  logic [GRID_W*GRID_H-1:0] map_out;
  logic [3:0]               cursor_x;
  logic [3:0]               cursor_y;
  logic                     busy;
  logic [15:0]              gen_count;

  modport master (
    output frame_start, step_req, run_en, btn_up, btn_down, btn_left,
           btn_right, btn_toggle,
    input  map_out, cursor_x, cursor_y, busy, gen_count
  );

  modport slave (
    input  frame_start, step_req, run_en, btn_up, btn_down, btn_left,
           btn_right, btn_toggle,
    output map_out, cursor_x, cursor_y, busy, gen_count
  );
endinterface

// File: rtl/life_cell_rule.sv
// Purpose: Conway rule for one cell from its 3x3 neighbourhood.
// Latency: combinational.
// Backpressure: none.
// Ports: nbhd[8:0] row-major 3x3 window (bit 4 = centre); next_alive = result.
module life_cell_rule (
  input  logic [8:0] nbhd,
  output logic       next_alive
);
  logic [3:0] count;

  always_comb begin
    count = '0;
    for (int i = 0; i < 9; i++) begin
      if (i != 4) count = count + {3'b000, nbhd[i]};
    end
    next_alive = nbhd[4] ? (count == 4'd2 || count == 4'd3) : (count == 4'd3);
  end
endmodule

// File: rtl/life_map_ctrl.sv
// Purpose: owns the displayed Life map; steps one cell/clk into a shadow, commits at frame_start.
// Latency: step_req->busy 1 clk; N clks compute; commit 1 clk after frame_start.
// Backpressure: requests while busy are held in 1-deep pending flags; extras dropped.
// Ports: clk, reset (sync, active high), bus (life_map_ctrl_if.slave).
// Build option: LIFE_WRAP_EN makes the grid toroidal; otherwise off-grid cells are dead.
module life_map_ctrl
  import life_pkg::*;
#(
  parameter int                         GRID_W          = LIFE_GRID_W,
  parameter int                         GRID_H          = LIFE_GRID_H,
  parameter logic [GRID_W*GRID_H-1:0]   INIT_MAP        = '0,
  parameter int                         FRAMES_PER_STEP = 30
) (
  input logic            clk,
  input logic            reset,
  life_map_ctrl_if.slave bus
);
  localparam int              N     = GRID_W * GRID_H;
  localparam int              IW    = $clog2(N);
  localparam int              FCW   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [3:0]      X_MAX = 4'(GRID_W - 1);
  localparam logic [3:0]      Y_MAX = 4'(GRID_H - 1);
  localparam logic [IW-1:0]   LAST  = IW'(N - 1);
  localparam logic [FCW-1:0]  F_MAX = FCW'(FRAMES_PER_STEP - 1);

  life_state_e    state_q, state_d;
  logic [N-1:0]   map_q, shadow_q;
  logic [IW-1:0]  idx_q, tog_idx_q, cur_idx;
  logic [3:0]     cx_q, cy_q, cur_x_q, cur_y_q;
  logic [FCW-1:0] frame_cnt_q;
  logic [15:0]    gen_q;
  logic           pend_step_q, pend_tog_q;
  logic           auto_tick, req, start, commit, busy;
  logic [N-1:0]   cur_mask, tog_mask, idle_mask;
  logic [8:0]     nbhd;
  logic           next_cell;
  int             nx, ny;

  assign auto_tick = bus.frame_start & bus.run_en & (frame_cnt_q == F_MAX);
  // step_req and an auto tick in the same cycle collapse into one request.
  assign req       = bus.step_req | auto_tick;
  assign busy      = (state_q != IDLE);
  assign cur_idx   = IW'(cell_idx(int'(cur_x_q), int'(cur_y_q), GRID_W));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE:        if (req || pend_step_q) begin state_d = COMPUTE; start = 1'b1; end
      COMPUTE:     if (idx_q == LAST) state_d = WAIT_COMMIT;
      WAIT_COMMIT: if (bus.frame_start) begin state_d = IDLE; commit = 1'b1; end
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_mask           = '0;
    cur_mask[cur_idx]  = 1'b1;
    tog_mask           = '0;
    tog_mask[tog_idx_q] = 1'b1;
    // In IDLE a button toggle acts directly; a toggle that arrived in the
    // commit cycle itself is still pending here and is applied now.
    idle_mask = (bus.btn_toggle ? cur_mask : '0) ^ (pend_tog_q ? tog_mask : '0);
  end

  // 3x3 window around the cell being computed, read from the committed map.
  always_comb begin
    nbhd = '0;
    nx   = 0;
    ny   = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(cx_q) + dx;
        ny = int'(cy_q) + dy;
`ifdef LIFE_WRAP_EN
        if (nx < 0) nx = GRID_W - 1; else if (nx >= GRID_W) nx = 0;
        if (ny < 0) ny = GRID_H - 1; else if (ny >= GRID_H) ny = 0;
        nbhd[(dy + 1) * 3 + (dx + 1)] = map_q[IW'(cell_idx(nx, ny, GRID_W))];
`else
        if (nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H)
          nbhd[(dy + 1) * 3 + (dx + 1)] = map_q[IW'(cell_idx(nx, ny, GRID_W))];
`endif
      end
    end
  end

  life_cell_rule u_rule (
    .nbhd       (nbhd),
    .next_alive (next_cell)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      map_q       <= INIT_MAP;
      shadow_q    <= INIT_MAP;
      idx_q       <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      tog_idx_q   <= '0;
      frame_cnt_q <= '0;
      gen_q       <= '0;
      pend_step_q <= 1'b0;
      pend_tog_q  <= 1'b0;
    end else begin
      if (!bus.run_en)          frame_cnt_q <= '0;
      else if (bus.frame_start) frame_cnt_q <= auto_tick ? '0 : frame_cnt_q + FCW'(1);

      if (start)             pend_step_q <= 1'b0;
      else if (busy && req)  pend_step_q <= 1'b1;

      // cx/cy track idx so the window needs no division.
      if (start) begin
        idx_q <= '0;
        cx_q  <= '0;
        cy_q  <= '0;
      end else if (state_q == COMPUTE) begin
        shadow_q[idx_q] <= next_cell;
        idx_q           <= idx_q + IW'(1);
        if (cx_q == X_MAX) begin
          cx_q <= '0;
          cy_q <= cy_q + 4'd1;
        end else begin
          cx_q <= cx_q + 4'd1;
        end
      end

      if (commit) begin
        map_q <= shadow_q ^ (pend_tog_q ? tog_mask : '0);
        gen_q <= gen_q + 16'd1;
      end else if (state_q == IDLE) begin
        map_q <= map_q ^ idle_mask;
      end

      // Pending toggle: a second press while pending cancels the first.
      if (state_q == IDLE) begin
        pend_tog_q <= 1'b0;
      end else if (commit) begin
        pend_tog_q <= bus.btn_toggle;
        if (bus.btn_toggle) tog_idx_q <= cur_idx;
      end else if (bus.btn_toggle) begin
        pend_tog_q <= ~pend_tog_q;
        if (!pend_tog_q) tog_idx_q <= cur_idx;
      end

      if (bus.btn_up && !bus.btn_down && cur_y_q != 4'd0)         cur_y_q <= cur_y_q - 4'd1;
      else if (bus.btn_down && !bus.btn_up && cur_y_q != Y_MAX)   cur_y_q <= cur_y_q + 4'd1;
      if (bus.btn_left && !bus.btn_right && cur_x_q != 4'd0)      cur_x_q <= cur_x_q - 4'd1;
      else if (bus.btn_right && !bus.btn_left && cur_x_q != X_MAX) cur_x_q <= cur_x_q + 4'd1;
    end
  end

  assign bus.map_out   = map_q;
  assign bus.cursor_x  = cur_x_q;
  assign bus.cursor_y  = cur_y_q;
  assign bus.busy      = busy;
  assign bus.gen_count = gen_q;
endmodule

// File: tb/tb_life_map_ctrl.sv
// Purpose: self-checking bench for life_map_ctrl against a grid-level Life model.
// Latency: n/a.
// Backpressure: n/a.
module tb_life_map_ctrl;
  localparam int         W    = 10;
  localparam int         H    = 10;
  localparam int         N    = W * H;
  localparam int         FPS  = 3;
  localparam logic [99:0] INIT = 100'h7 << 54;  // blinker (4,5),(5,5),(6,5)

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  life_map_ctrl_if #(.GRID_W(W), .GRID_H(H)) bus ();

  life_map_ctrl #(
    .GRID_W(W), .GRID_H(H), .INIT_MAP(INIT), .FRAMES_PER_STEP(FPS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  bit [99:0]  m_map;
  int         mx, my, m_gen;

  function automatic bit [99:0] life_step(input bit [99:0] m);
    bit [99:0] r = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int xx = x + dx;
            int yy = y + dy;
            if (dx == 0 && dy == 0) continue;
`ifdef LIFE_WRAP_EN
            xx = (xx + W) % W;
            yy = (yy + H) % H;
`else
            if (xx < 0 || xx >= W || yy < 0 || yy >= H) continue;
`endif
            n += int'(m[yy * W + xx]);
          end
        end
        r[y * W + x] = (n == 3) || (m[y * W + x] && n == 2);
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_btns(input bit u, input bit d, input bit l, input bit r);
    bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r;
    tick();
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
    if (u && !d) my = (my > 0) ? my - 1 : 0;
    if (d && !u) my = (my < H - 1) ? my + 1 : H - 1;
    if (l && !r) mx = (mx > 0) ? mx - 1 : 0;
    if (r && !l) mx = (mx < W - 1) ? mx + 1 : W - 1;
    check("cursor_x", bus.cursor_x, mx);
    check("cursor_y", bus.cursor_y, my);
  endtask

  task automatic move_to(input int x, input int y);
    for (int k = 0; k < 2 * W && mx != x; k++) drive_btns(0, 0, mx > x, mx < x);
    for (int k = 0; k < 2 * H && my != y; k++) drive_btns(my > y, my < y, 0, 0);
  endtask

  task automatic toggle_idle();
    bus.btn_toggle = 1; tick(); bus.btn_toggle = 0;
    m_map[my * W + mx] = ~m_map[my * W + mx];
    check("idle_toggle", bus.map_out, m_map);
  endtask

  task automatic set_cell(input int x, input int y, input bit v);
    if (m_map[y * W + x] != v) begin
      move_to(x, y);
      toggle_idle();
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < N; i++) set_cell(i % W, i / W, 1'b0);
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1; tick(); bus.frame_start = 0;
  endtask

  task automatic do_step(input string tag);
    bit [99:0] nxt = life_step(m_map);
    bus.step_req = 1; tick(); bus.step_req = 0;
    check({tag, " busy"}, bus.busy, 1);
    repeat (N) tick();
    check({tag, " hold"}, bus.map_out, m_map);
    frame_pulse();
    m_map = nxt;
    m_gen++;
    check({tag, " map"}, bus.map_out, m_map);
    check({tag, " gen"}, bus.gen_count, 16'(m_gen));
    check({tag, " idle"}, bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [99:0] exp_map;
    bus.frame_start = 0; bus.step_req = 0; bus.run_en = 0;
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
    bus.btn_toggle = 0;
    reset = 1;
    repeat (3) tick();
    m_map = INIT; mx = 0; my = 0; m_gen = 0;
    check("rst map", bus.map_out, INIT);
    check("rst cx", bus.cursor_x, 0);
    check("rst cy", bus.cursor_y, 0);
    check("rst busy", bus.busy, 0);
    check("rst gen", bus.gen_count, 0);
    reset = 0;
    tick();

    // Blinker oscillates.
    do_step("blink1");
    exp_map = (100'h1 << 45) | (100'h1 << 55) | (100'h1 << 65);
    check("blink vertical", bus.map_out, exp_map);
    do_step("blink2");
    check("blink restored", bus.map_out, INIT);

    // frame_start during COMPUTE ignored; step while busy pends; a third is dropped.
    bus.step_req = 1; tick(); bus.step_req = 0;
    repeat (20) tick();
    frame_pulse();
    check("early frame busy", bus.busy, 1);
    check("early frame map", bus.map_out, m_map);
    bus.step_req = 1; tick(); bus.step_req = 0;
    bus.step_req = 1; tick(); bus.step_req = 0;
    repeat (N - 23) tick();
    frame_pulse();
    m_map = life_step(m_map); m_gen++;
    check("pend commit map", bus.map_out, m_map);
    check("pend commit idle", bus.busy, 0);
    tick();
    check("pend restart", bus.busy, 1);
    repeat (N) tick();
    frame_pulse();
    m_map = life_step(m_map); m_gen++;
    check("pend2 map", bus.map_out, m_map);
    check("pend2 gen", bus.gen_count, 16'(m_gen));
    repeat (5) tick();
    check("no extra step", bus.busy, 0);

    // Block still life.
    clear_map();
    set_cell(2, 2, 1); set_cell(3, 2, 1); set_cell(2, 3, 1); set_cell(3, 3, 1);
    exp_map = m_map;
    for (int i = 0; i < 3; i++) do_step("block");
    check("block stable", bus.map_out, exp_map);

    // Toggle during COMPUTE lands at commit, at the latched position.
    move_to(3, 7);
    bus.step_req = 1; tick(); bus.step_req = 0;
    repeat (10) tick();
    bus.btn_toggle = 1; tick(); bus.btn_toggle = 0;
    drive_btns(0, 0, 0, 1);
    repeat (N - 12) tick();
    check("tog hold", bus.map_out, m_map);
    frame_pulse();
    m_map = life_step(m_map) ^ (100'h1 << 73); m_gen++;
    check("tog commit", bus.map_out, m_map);
    check("tog bit73", bus.map_out[73], 1);
    bus.step_req = 1; tick(); bus.step_req = 0;
    repeat (10) tick();
    bus.btn_toggle = 1; tick(); bus.btn_toggle = 0;
    repeat (3) tick();
    bus.btn_toggle = 1; tick(); bus.btn_toggle = 0;
    repeat (N - 15) tick();
    frame_pulse();
    m_map = life_step(m_map); m_gen++;
    check("tog cancel", bus.map_out, m_map);
    check("tog cancel bit73", bus.map_out[73], 0);

    // Cursor saturation and opposite presses.
    move_to(0, 0);
    for (int i = 0; i < 12; i++) drive_btns(0, 0, 0, 1);
    check("right sat", bus.cursor_x, 9);
    drive_btns(1, 0, 0, 0);
    check("up sat", bus.cursor_y, 0);
    drive_btns(1, 1, 1, 1);

    // Random cursor traffic.
    for (int i = 0; i < 40; i++) begin
      bit [3:0] b = 4'($urandom);
      drive_btns(b[0], b[1], b[2], b[3]);
    end

    // Random soup.
    clear_map();
    for (int i = 0; i < 14; i++) set_cell($urandom_range(0, W - 1), $urandom_range(0, H - 1), 1);
    for (int i = 0; i < 4; i++) do_step("soup");

    // Glider heading toward the right edge.
    clear_map();
    set_cell(8, 2, 1); set_cell(9, 3, 1); set_cell(7, 4, 1); set_cell(8, 4, 1); set_cell(9, 4, 1);
    for (int i = 0; i < 8; i++) do_step("glider");

    // Auto-step: one tick every FPS frames while run_en is high.
    bus.run_en = 1;
    for (int f = 1; f < FPS; f++) begin
      frame_pulse();
      check("auto wait", bus.busy, 0);
      repeat (2) tick();
    end
    frame_pulse();
    check("auto tick", bus.busy, 1);
    bus.run_en = 0;
    repeat (N) tick();
    frame_pulse();
    m_map = life_step(m_map); m_gen++;
    check("auto map", bus.map_out, m_map);
    check("auto gen", bus.gen_count, 16'(m_gen));

    // Reset mid-COMPUTE discards everything.
    bus.step_req = 1; tick(); bus.step_req = 0;
    repeat (40) tick();
    reset = 1; tick();
    check("mid rst map", bus.map_out, INIT);
    check("mid rst busy", bus.busy, 0);
    check("mid rst gen", bus.gen_count, 0);
    check("mid rst cx", bus.cursor_x, 0);
    reset = 0;
    repeat (N + 5) tick();
    frame_pulse();
    tick();
    check("post rst gen", bus.gen_count, 0);
    check("post rst map", bus.map_out, INIT);
    check("post rst busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/life_map_ctrl.md
# life_map_ctrl

Game-of-Life map controller that owns the cell map displayed by the VGA pattern generator. It computes successive generations one cell per clock into a shadow buffer, applies user cursor moves and cell toggles, and commits the new map only at frame start so the display never shows a half-updated grid. It sits between the board buttons/switches and the `map` input of the VGA generator; `frame_start` comes from the VGA timing chain.

## Interface
- `GRID_W`, default 10: grid width in cells.
- `GRID_H`, default 10: grid height in cells.
- `INIT_MAP`, default 100'b0: map value loaded on reset. Cell (x,y) is bit `x + y*GRID_W`.
- `FRAMES_PER_STEP`, default 30: frames between automatic steps while `run_en` is high.

- `clk`, in, 1: single clock. All ports are synchronous to it.
- `reset`, in, 1: synchronous, active-high reset.
- `frame_start`, in, 1: one-cycle pulse at the start of vertical blank.
- `step_req`, in, 1: one-cycle pulse requesting one generation.
- `run_en`, in, 1: level; enables automatic stepping.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, in, 1 each: one-cycle cursor-move pulses.
- `btn_toggle`, in, 1: one-cycle pulse that inverts the cell under the cursor.
- `map_out`, out, GRID_W*GRID_H: committed map, driving the display.
- `cursor_x`, `cursor_y`, out, 4 each: cursor cell coordinates.
- `busy`, out, 1: high in COMPUTE and WAIT_COMMIT.
- `gen_count`, out, 16: number of committed generations. Wraps at 0xFFFF→0.

## Operation
- Reset values:
  - `map_out` = INIT_MAP; shadow map = INIT_MAP.
  - `cursor_x` = `cursor_y` = 0; `gen_count` = 0; `busy` = 0.
  - Frame counter = 0; pending-step and pending-toggle flags cleared; FSM in IDLE.
- **IDLE**:
  - A step trigger moves the FSM to COMPUTE and clears the cell index. A step trigger is `step_req`, a pending step, or an auto tick.
  - `btn_toggle` flips `map_out[cursor]` directly.
- **COMPUTE**:
  - Processes cell index i = 0 … N-1, one per cycle, where N = GRID_W*GRID_H.
  - The neighbour count is a 3-bit+1 sum (0–8) of the 8 neighbours, read from `map_out`.
  - Cells outside the grid count as dead (see Configuration for the alternative).
  - Next state of the cell is 1 if (alive and count is 2 or 3) or (dead and count is 3); otherwise 0. It is written to shadow[i].
  - After i = N-1, go to WAIT_COMMIT.
- **WAIT_COMMIT**:
  - On `frame_start`: `map_out` ← shadow, `gen_count`++, go to IDLE.
  - If a toggle is pending, it is applied to the new map in that same commit cycle (XOR at the cursor position), and the flag clears.
- **Arbitration**:
  - While `busy`, a `step_req` or auto tick sets the single-depth pending-step flag. Further requests are dropped.
  - While `busy`, `btn_toggle` sets the single-depth pending-toggle flag, latching the cursor position at that moment. A second toggle while pending clears the flag (the two toggles cancel).
- **Cursor**:
  - Moves act in every state, in the cycle after the pulse.
  - Movement saturates at 0 and at GRID_W-1 / GRID_H-1; there is no wrap.
  - Simultaneous opposite presses cancel.
- **Auto-step**:
  - The frame counter increments on `frame_start` while `run_en` is high.
  - When it reaches FRAMES_PER_STEP-1 it resets to 0 and issues one auto tick.
  - When `run_en` is low, the counter holds at 0.
- `step_req` coinciding with an auto tick counts as one step.

## Timing
- `step_req` at cycle t → `busy`=1 at t+1. The last cell is written at t+N; WAIT_COMMIT starts at t+N+1.
- `frame_start` at cycle f in WAIT_COMMIT → `map_out` and `gen_count` update at f+1, and `busy`=0 at f+1.
- A pending step re-enters COMPUTE at f+2.
- `frame_start` arriving during COMPUTE is ignored for commit; only the first `frame_start` seen in WAIT_COMMIT commits.
- Reset mid-COMPUTE: the next cycle shows all reset values; the partial shadow is discarded.
- IDLE toggle: `map_out` changes one cycle after `btn_toggle`.

## Configuration
- `LIFE_WRAP_EN` defined: toroidal grid. Neighbour coordinates wrap modulo GRID_W / GRID_H, so cell (0,0) neighbours (GRID_W-1, GRID_H-1).
- Not defined: out-of-grid neighbours are dead; no modulo logic is synthesised.

## Structure
- A shared package `life_pkg` holds:
  - the FSM state enum (IDLE, COMPUTE, WAIT_COMMIT);
  - the default grid dimensions;
  - a `cell_idx(x,y)` function.
- Sub-module `life_cell_rule`: combinational. It takes the 9-bit neighbourhood (centre plus 8 neighbours) and outputs the next state. It is instantiated once.

## Test plan
- Blinker (cells (4,5),(5,5),(6,5)) → `step_req`, one `frame_start` → map = (5,4),(5,5),(5,6), `gen_count`=1. A second step restores the original map, `gen_count`=2.
- Block still life (2,2),(3,2),(2,3),(3,3) → 3 steps → map unchanged, `gen_count`=3.
- `btn_toggle` at cursor (3,7) during COMPUTE → bit 73 flipped on the committed map in the commit cycle and not before. A second toggle while pending → no flip.
- 12 `btn_right` pulses from x=0 → `cursor_x`=9. `btn_up` at y=0 → `cursor_y` stays 0.
- `reset` asserted 40 cycles into COMPUTE → next cycle `map_out`=INIT_MAP, `busy`=0, `gen_count`=0. No later commit without a new step.
- With `LIFE_WRAP_EN`, glider at the right edge, `run_en`=1, FRAMES_PER_STEP=2 → glider reappears at column 0 after the expected generations. Without the macro it decays into a block at the edge.
